// File: rtl/keypad_scanner.sv
// 4x4 keypad row scanner with single-key debounce; presents a one-hot {row,col} key code.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV     = 12000,
  parameter int unsigned DEBOUNCE_CNT = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] col_in,
  output logic [3:0] row_drive,
  output logic [7:0] key_code,
  output logic       key_press,
  output logic       key_release
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CNT + 1);

  typedef enum logic [1:0] {
    SCAN  = 2'd0,
    DEB_P = 2'd1,
    HELD  = 2'd2,
    DEB_R = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [3:0]         sync1, cs;
  logic [DIV_W-1:0]   div;
  logic               tick;
  logic [CNT_W-1:0]   cnt, cnt_nxt, cnt_inc;
  logic               cnt_done;
  logic [3:0]         cap_row, cap_row_nxt;
  logic [3:0]         cap_col, cap_col_nxt;
  logic [3:0]         row_nxt, row_rot;
  logic [7:0]         code_nxt;
  logic               press_nxt, release_nxt;
  logic               cs_onehot;

  // Two-flop synchronizer for the asynchronous column inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 4'd0;
      cs    <= 4'd0;
    end else begin
      sync1 <= col_in;
      cs    <= sync1;
    end
  end

  // Free-running row dwell / sample divider.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div <= '0;
    end else if (div == DIV_W'(SCAN_DIV - 1)) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  assign tick      = (div == DIV_W'(SCAN_DIV - 1));
  assign cs_onehot = (cs != 4'd0) && ((cs & (cs - 4'd1)) == 4'd0);
  assign row_rot   = {row_drive[0], row_drive[3:1]};
  assign cnt_inc   = (cnt == CNT_W'(DEBOUNCE_CNT)) ? cnt : cnt + CNT_W'(1);
  assign cnt_done  = (cnt_inc == CNT_W'(DEBOUNCE_CNT));

  // State, capture and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= SCAN;
      cnt         <= '0;
      cap_row     <= 4'd0;
      cap_col     <= 4'd0;
      row_drive   <= 4'b1000;
      key_code    <= 8'd0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      cap_row     <= cap_row_nxt;
      cap_col     <= cap_col_nxt;
      row_drive   <= row_nxt;
      key_code    <= code_nxt;
      key_press   <= press_nxt;
      key_release <= release_nxt;
    end
  end

  // Scan / debounce decisions, taken only on sample ticks.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    cap_row_nxt = cap_row;
    cap_col_nxt = cap_col;
    row_nxt     = row_drive;
    code_nxt    = key_code;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    if (tick) begin
      case (state)
        SCAN: begin
          if (cs_onehot) begin
            cap_row_nxt = row_drive;
            cap_col_nxt = cs;
            cnt_nxt     = '0;
            state_nxt   = DEB_P;
          end else begin
            row_nxt = row_rot;
          end
        end
        DEB_P: begin
          if (cs == cap_col) begin
            cnt_nxt = cnt_inc;
            if (cnt_done) begin
              code_nxt  = {cap_row, cap_col};
              press_nxt = 1'b1;
              cnt_nxt   = '0;
              state_nxt = HELD;
            end
          end else begin
            cnt_nxt   = '0;
            row_nxt   = row_rot;
            state_nxt = SCAN;
          end
        end
        HELD: begin
          if (cs != cap_col) begin
            cnt_nxt   = '0;
            state_nxt = DEB_R;
          end
        end
        DEB_R: begin
          if (cs == cap_col) begin
            cnt_nxt   = '0;
            state_nxt = HELD;
          end else if (cs == 4'd0) begin
            cnt_nxt = cnt_inc;
            if (cnt_done) begin
              code_nxt    = 8'd0;
              release_nxt = 1'b1;
              cnt_nxt     = '0;
              row_nxt     = row_rot;
              state_nxt   = SCAN;
            end
          end else begin
            cnt_nxt = '0;
          end
        end
        default: state_nxt = SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized bench for keypad_scanner against a tick-level behavioural keypad model.
module tb_keypad_scanner;

  localparam int unsigned SCAN_DIV = 4;
  localparam int          DEB      = 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] col_in;
  logic [3:0] row_drive;
  logic [7:0] key_code;
  logic       key_press;
  logic       key_release;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: scanned row index, candidate column, reported / releasing flags.
  int         m_row;
  logic [3:0] m_cand;
  bit         m_rep;
  bit         m_rel;
  int         m_run;
  logic [7:0] m_code;
  bit         m_press;
  bit         m_relp;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEB)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .col_in     (col_in),
    .row_drive  (row_drive),
    .key_code   (key_code),
    .key_press  (key_press),
    .key_release(key_release)
  );

  function automatic logic [3:0] row_mask(input int r);
    logic [3:0] top;
    top = 4'b1000;
    return top >> r;
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_row = 0; m_cand = 4'd0; m_rep = 0; m_rel = 0; m_run = 0;
    m_code = 8'd0; m_press = 0; m_relp = 0;
  endtask

  // One sample tick of the keypad rules, given the column pattern seen on that tick.
  task automatic model_tick(input logic [3:0] col);
    m_press = 0;
    m_relp  = 0;
    if (m_cand == 4'd0) begin
      if ($countones(col) == 1) begin
        m_cand = col;
        m_run  = 0;
      end else begin
        m_row = (m_row + 1) % 4;
      end
    end else if (!m_rep) begin
      if (col == m_cand) begin
        m_run++;
        if (m_run == DEB) begin
          m_rep   = 1;
          m_code  = {row_mask(m_row), m_cand};
          m_press = 1;
        end
      end else begin
        m_cand = 4'd0;
        m_run  = 0;
        m_row  = (m_row + 1) % 4;
      end
    end else if (!m_rel) begin
      if (col != m_cand) begin
        m_rel = 1;
        m_run = 0;
      end
    end else begin
      if (col == m_cand) begin
        m_rel = 0;
        m_run = 0;
      end else if (col == 4'd0) begin
        m_run++;
        if (m_run == DEB) begin
          m_code = 8'd0;
          m_relp = 1;
          m_rep  = 0;
          m_rel  = 0;
          m_cand = 4'd0;
          m_run  = 0;
          m_row  = (m_row + 1) % 4;
        end
      end else begin
        m_run = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("row_drive",   {4'd0, row_drive},   {4'd0, row_mask(m_row)});
    check("key_code",    key_code,            m_code);
    check("key_press",   {7'd0, key_press},   {7'd0, m_press});
    check("key_release", {7'd0, key_release}, {7'd0, m_relp});
  endtask

  // Hold col_in for one full tick period; the decision edge is the 4th rising edge.
  task automatic step(input logic [3:0] col);
    col_in = col;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (i == 3) begin
        model_tick(col);
      end else begin
        m_press = 0;
        m_relp  = 0;
      end
      compare_all();
    end
  endtask

  // Column pattern the physical keypad returns for key (r,c) under the currently driven row.
  function automatic logic [3:0] key_col(input int r, input int c);
    logic [3:0] top;
    top = 4'b1000;
    return (r >= 0 && r == m_row) ? (top >> c) : 4'd0;
  endfunction

  task automatic press_until_captured(input int r, input int c);
    for (int i = 0; i < 8 && m_cand == 4'd0; i++) step(key_col(r, c));
  endtask

  task automatic do_reset_release();
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [3:0] seq [5];
    logic [3:0] col;
    int r, c, n, p;
    seq = '{4'b0100, 4'b0010, 4'b0001, 4'b1000, 4'b0100};
    reset_n = 1'b0;
    col_in  = 4'd0;
    model_reset();

    // Reset values and idle row rotation.
    repeat (3) @(posedge clk);
    #1;
    check("rst_row",  {4'd0, row_drive}, 8'b0000_1000);
    check("rst_code", key_code, 8'd0);
    check("rst_press", {7'd0, key_press}, 8'd0);
    check("rst_release", {7'd0, key_release}, 8'd0);
    do_reset_release();
    for (int i = 0; i < 5; i++) begin
      step(4'd0);
      check("idle_rot", {4'd0, row_drive}, {4'd0, seq[i]});
    end

    // Press row2/col1.
    press_until_captured(2, 1);
    repeat (DEB) step(key_col(2, 1));
    check("r2c1_code", key_code, 8'b0010_0100);
    check("r2c1_press", {7'd0, key_press}, 8'd1);
    repeat (3) step(key_col(2, 1));
    // One-tick release glitch returns to held without a pulse.
    step(4'd0);
    step(key_col(2, 1));
    step(key_col(2, 1));
    check("glitch_code", key_code, 8'b0010_0100);
    // Clean release.
    repeat (DEB + 1) step(4'd0);
    check("rel_code", key_code, 8'd0);
    check("rel_pulse", {7'd0, key_release}, 8'd1);

    // Bounce inside press debounce: scan resumes at row3.
    press_until_captured(2, 1);
    step(key_col(2, 1));
    step(4'd0);
    check("bounce_row",  {4'd0, row_drive}, 8'b0000_0001);
    check("bounce_code", key_code, 8'd0);

    // Chord on row0 is ignored.
    for (int i = 0; i < 4 && m_row != 0; i++) step(4'd0);
    step(4'b0110);
    check("chord_row",  {4'd0, row_drive}, 8'b0000_0100);
    check("chord_code", key_code, 8'd0);

    // Mode key row3/col3, then asynchronous reset while held.
    press_until_captured(3, 3);
    repeat (DEB) step(key_col(3, 3));
    check("mode_code", key_code, 8'b0001_0001);
    step(key_col(3, 3));
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("areset_code", key_code, 8'd0);
    check("areset_row",  {4'd0, row_drive}, 8'b0000_1000);
    check("areset_release", {7'd0, key_release}, 8'd0);
    repeat (2) @(posedge clk);
    #1;
    check("areset_release2", {7'd0, key_release}, 8'd0);
    col_in = 4'd0;
    do_reset_release();

    // Randomized press / hold / release scenarios with bounce and chord noise.
    for (int s = 0; s < 60; s++) begin
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      n = $urandom_range(1, 25);
      for (int k = 0; k < n; k++) begin
        col = key_col(r, c);
        p = $urandom_range(0, 99);
        if (p < 10) col = 4'd0;
        else if (p < 15) col = col | row_mask($urandom_range(0, 3));
        step(col);
      end
      n = $urandom_range(1, 12);
      for (int k = 0; k < n; k++) begin
        col = 4'd0;
        p = $urandom_range(0, 99);
        if (p < 10) col = key_col(r, c);
        else if (p < 14) col = 4'($urandom_range(1, 15));
        step(col);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
